// File: rtl/shift_pkg.sv
// Shared encodings for the shift_runner LED shifter.
// Mode, direction and FSM state definitions.
package shift_pkg;

    localparam logic [1:0] MODE_LOGIC = 2'b00;
    localparam logic [1:0] MODE_ARITH = 2'b01;
    localparam logic [1:0] MODE_ROT   = 2'b10;
    localparam logic [1:0] MODE_RSVD  = 2'b11;

    localparam logic DIR_LEFT  = 1'b0;
    localparam logic DIR_RIGHT = 1'b1;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

endpackage

// File: rtl/shift_core.sv
// Combinational shifter: logical, arithmetic and rotate by a runtime
// amount; amounts >= width saturate, rotates wrap modulo width.
module shift_core
    import shift_pkg::*;
#(
    parameter int DATA_WIDTH = 4,
    localparam int AMT_W = $clog2(DATA_WIDTH)
) (
    input  logic [DATA_WIDTH-1:0] data,
    input  logic [AMT_W-1:0]      amount,
    input  logic                  direction,
    input  logic [1:0]            mode,
    output logic [DATA_WIDTH-1:0] shifted
);

    int unsigned rot;
    int unsigned rot_c;

    always_comb begin
        rot     = 32'(amount) % 32'(DATA_WIDTH);
        // a zero rotate makes rot_c == width, which shifts to all zeros
        rot_c   = 32'(DATA_WIDTH) - rot;
        shifted = data;
        case (mode)
            MODE_LOGIC: begin
                if (direction == DIR_RIGHT) shifted = data >> amount;
                else                        shifted = data << amount;
            end
            MODE_ARITH: begin
                if (direction == DIR_RIGHT) shifted = $signed(data) >>> amount;
                else                        shifted = data << amount;
            end
            MODE_ROT: begin
                if (direction == DIR_RIGHT) shifted = (data >> rot) | (data << rot_c);
                else                        shifted = (data << rot) | (data >> rot_c);
            end
            default: shifted = data;
        endcase
    end

endmodule

// File: rtl/shift_runner.sv
// Registered running-lights shifter: single-step in IDLE, automatic
// shift every TICK_DIV clocks in RUN, with load overriding shifts.
module shift_runner
    import shift_pkg::*;
#(
    parameter int DATA_WIDTH = 4,
    parameter int TICK_DIV = 4,
    parameter logic [DATA_WIDTH-1:0] RESET_VALUE = '0,
    localparam int AMT_W = $clog2(DATA_WIDTH)
) (
    input  logic                  FPGA_CLK,
    input  logic                  RESET,
    input  logic                  load,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic [AMT_W-1:0]      shift_amount,
    input  logic                  direction,
    input  logic [1:0]            mode,
    input  logic                  run_en,
    input  logic                  step,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  tick,
    output logic                  running
);

    localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TICK_DIV - 1);

    state_t                  state_q, state_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0]   data_q, data_d;
    logic                    tick_q, tick_d;
    logic                    running_q, running_d;
    logic                    shift_ev;
    logic [DATA_WIDTH-1:0]   shifted;

    shift_core #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_core (
        .data      (data_q),
        .amount    (shift_amount),
        .direction (direction),
        .mode      (mode),
        .shifted   (shifted)
    );

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        data_d   = data_q;
        tick_d   = 1'b0;
        shift_ev = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (run_en) begin
                    state_d = ST_RUN;
                    cnt_d   = '0;
                end else if (step) begin
                    shift_ev = 1'b1;
                end
            end
            ST_RUN: begin
                if (!run_en) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_MAX) begin
                    shift_ev = 1'b1;
                    cnt_d    = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
        // load wins over a coincident shift and restarts the divider
        if (load) begin
            data_d = data_in;
            cnt_d  = '0;
        end else if (shift_ev) begin
            data_d = shifted;
            tick_d = 1'b1;
        end
        running_d = (state_d == ST_RUN);
    end

    always_ff @(posedge FPGA_CLK) begin
        if (RESET) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            data_q    <= RESET_VALUE;
            tick_q    <= 1'b0;
            running_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            data_q    <= data_d;
            tick_q    <= tick_d;
            running_q <= running_d;
        end
    end

    assign data_out = data_q;
    assign tick     = tick_q;
    assign running  = running_q;

endmodule

// File: tb/tb_shift_runner.sv
// Directed bench for shift_runner: table of IDLE load/step vectors
// plus hand sequences for RUN timing, collisions, stop and reset.
module tb_shift_runner;

    logic       clk = 1'b0;
    logic       rst;
    logic       load;
    logic [3:0] din;
    logic [1:0] amt;
    logic       dir;
    logic [1:0] md;
    logic       run_en;
    logic       stp;
    logic [3:0] dout;
    logic       tck;
    logic       run;

    logic       load6;
    logic [5:0] din6;
    logic [2:0] amt6;
    logic       dir6;
    logic [1:0] md6;
    logic       stp6;
    logic [5:0] dout6;
    logic       tck6;
    logic       run6;

    int n_chk = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    shift_runner u4 (
        .FPGA_CLK     (clk),
        .RESET        (rst),
        .load         (load),
        .data_in      (din),
        .shift_amount (amt),
        .direction    (dir),
        .mode         (md),
        .run_en       (run_en),
        .step         (stp),
        .data_out     (dout),
        .tick         (tck),
        .running      (run)
    );

    shift_runner #(
        .DATA_WIDTH (6),
        .TICK_DIV   (1)
    ) u6 (
        .FPGA_CLK     (clk),
        .RESET        (rst),
        .load         (load6),
        .data_in      (din6),
        .shift_amount (amt6),
        .direction    (dir6),
        .mode         (md6),
        .run_en       (1'b0),
        .step         (stp6),
        .data_out     (dout6),
        .tick         (tck6),
        .running      (run6)
    );

    typedef struct {
        logic       ld;
        logic [3:0] d;
        logic       st;
        logic [1:0] a;
        logic       dr;
        logic [1:0] m;
        logic [3:0] exp_d;
        logic       exp_t;
    } vec_t;

    vec_t vt[14];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_tick(output int n);
        n = 0;
        do begin
            cyc();
            n++;
        end while (!tck && n < 20);
    endtask

    initial begin
        int n;
        int tcount;
        logic [3:0] rot_exp[5];

        rot_exp[0] = 4'b1000;
        rot_exp[1] = 4'b0100;
        rot_exp[2] = 4'b0010;
        rot_exp[3] = 4'b0001;
        rot_exp[4] = 4'b1000;

        //         ld    d        st    a      dr    m       exp_d    t
        vt[0]  = '{1'b1, 4'b1011, 1'b0, 2'd0, 1'b0, 2'b00, 4'b1011, 1'b0};
        vt[1]  = '{1'b0, 4'b0000, 1'b1, 2'd1, 1'b0, 2'b00, 4'b0110, 1'b1};
        vt[2]  = '{1'b0, 4'b0000, 1'b0, 2'd1, 1'b0, 2'b00, 4'b0110, 1'b0};
        vt[3]  = '{1'b1, 4'b1000, 1'b0, 2'd0, 1'b0, 2'b00, 4'b1000, 1'b0};
        vt[4]  = '{1'b0, 4'b0000, 1'b1, 2'd2, 1'b1, 2'b01, 4'b1110, 1'b1};
        vt[5]  = '{1'b1, 4'b1001, 1'b0, 2'd0, 1'b0, 2'b00, 4'b1001, 1'b0};
        vt[6]  = '{1'b0, 4'b0000, 1'b1, 2'd1, 1'b0, 2'b01, 4'b0010, 1'b1};
        vt[7]  = '{1'b1, 4'b1101, 1'b0, 2'd0, 1'b0, 2'b00, 4'b1101, 1'b0};
        vt[8]  = '{1'b0, 4'b0000, 1'b1, 2'd3, 1'b0, 2'b10, 4'b1110, 1'b1};
        vt[9]  = '{1'b0, 4'b0000, 1'b1, 2'd2, 1'b0, 2'b11, 4'b1110, 1'b1};
        vt[10] = '{1'b0, 4'b0000, 1'b1, 2'd3, 1'b1, 2'b00, 4'b0001, 1'b1};
        vt[11] = '{1'b1, 4'b0111, 1'b1, 2'd1, 1'b0, 2'b00, 4'b0111, 1'b0};
        vt[12] = '{1'b0, 4'b0000, 1'b1, 2'd0, 1'b0, 2'b00, 4'b0111, 1'b1};
        vt[13] = '{1'b0, 4'b0000, 1'b1, 2'd1, 1'b1, 2'b10, 4'b1011, 1'b1};

        rst = 1'b1; load = 1'b0; din = '0; amt = '0; dir = 1'b0;
        md = 2'b00; run_en = 1'b1; stp = 1'b0;
        load6 = 1'b0; din6 = '0; amt6 = '0; dir6 = 1'b0; md6 = 2'b00;
        stp6 = 1'b0;

        cyc();
        chk("reset_data", 32'(dout), 32'h0);
        chk("reset_tick", 32'(tck), 32'h0);
        chk("reset_running", 32'(run), 32'h0);
        rst = 1'b0;
        run_en = 1'b0;

        for (int i = 0; i < 14; i++) begin
            load = vt[i].ld; din = vt[i].d; stp = vt[i].st;
            amt = vt[i].a; dir = vt[i].dr; md = vt[i].m;
            cyc();
            chk($sformatf("vec%0d_data", i), 32'(dout), 32'(vt[i].exp_d));
            chk($sformatf("vec%0d_tick", i), 32'(tck), 32'(vt[i].exp_t));
        end
        load = 1'b0; stp = 1'b0;

        // automatic rotate right, step held high to prove it is ignored
        load = 1'b1; din = 4'b0001;
        cyc();
        load = 1'b0;
        md = 2'b10; dir = 1'b1; amt = 2'd1; run_en = 1'b1; stp = 1'b1;
        cyc();
        chk("run_enter_running", 32'(run), 32'h1);
        chk("run_enter_tick", 32'(tck), 32'h0);
        for (int k = 0; k < 5; k++) begin
            wait_tick(n);
            chk($sformatf("rot%0d_gap", k), 32'(n), 32'd4);
            chk($sformatf("rot%0d_data", k), 32'(dout), 32'(rot_exp[k]));
        end

        // load lands in the cycle the divider reaches TICK_DIV-1
        repeat (3) cyc();
        load = 1'b1; din = 4'b0101;
        cyc();
        load = 1'b0;
        chk("collide_data", 32'(dout), 32'h5);
        chk("collide_tick", 32'(tck), 32'h0);
        wait_tick(n);
        chk("collide_gap", 32'(n), 32'd4);
        chk("collide_next", 32'(dout), 32'hA);

        run_en = 1'b0; stp = 1'b0;
        cyc();
        chk("stop_running", 32'(run), 32'h0);
        chk("stop_tick", 32'(tck), 32'h0);
        tcount = 0;
        repeat (8) begin
            cyc();
            if (tck) tcount++;
        end
        chk("stop_no_ticks", 32'(tcount), 32'h0);
        chk("stop_data", 32'(dout), 32'hA);

        md = 2'b11; stp = 1'b1;
        cyc();
        stp = 1'b0;
        chk("rsvd_data", 32'(dout), 32'hA);
        chk("rsvd_tick", 32'(tck), 32'h1);
        cyc();
        chk("rsvd_tick_drop", 32'(tck), 32'h0);

        // reset in the middle of RUN beats a coincident load
        md = 2'b10; dir = 1'b1; amt = 2'd1; run_en = 1'b1;
        repeat (3) cyc();
        chk("pre_rst_running", 32'(run), 32'h1);
        rst = 1'b1; load = 1'b1; din = 4'b1111;
        cyc();
        chk("midrst_data", 32'(dout), 32'h0);
        chk("midrst_tick", 32'(tck), 32'h0);
        chk("midrst_running", 32'(run), 32'h0);
        rst = 1'b0; din = 4'b0011;
        cyc();
        load = 1'b0;
        chk("post_rst_running", 32'(run), 32'h1);
        chk("post_rst_data", 32'(dout), 32'h3);
        wait_tick(n);
        chk("post_rst_gap", 32'(n), 32'd4);
        chk("post_rst_shift", 32'(dout), 32'h9);
        run_en = 1'b0;

        // 6-bit instance: out-of-range amounts
        load6 = 1'b1; din6 = 6'b101101;
        cyc();
        load6 = 1'b0; stp6 = 1'b1; md6 = 2'b00; dir6 = 1'b1; amt6 = 3'd7;
        cyc();
        stp6 = 1'b0;
        chk("w6_lsr7", 32'(dout6), 32'h00);
        chk("w6_lsr7_tick", 32'(tck6), 32'h1);
        load6 = 1'b1;
        cyc();
        load6 = 1'b0; stp6 = 1'b1; md6 = 2'b10;
        cyc();
        stp6 = 1'b0;
        chk("w6_ror7", 32'(dout6), 32'(6'b110110));
        load6 = 1'b1; din6 = 6'b101101;
        cyc();
        load6 = 1'b0; stp6 = 1'b1; md6 = 2'b01;
        cyc();
        stp6 = 1'b0;
        chk("w6_asr7", 32'(dout6), 32'(6'b111111));
        chk("w6_running", 32'(run6), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/shift_runner.md
Name: shift_runner

Overview:
- Registered, parametrised successor to the board-level barrel-shifter wrapper. Shift amount, direction and mode are runtime inputs instead of compile-time constants.
- Holds a data word and shifts it either on a single-step request or automatically every TICK_DIV clocks, giving a visible "running lights" pattern on the board LEDs.
- Sits between the switch/button inputs and the LED outputs in the FPGA top level.

Parameters:
- DATA_WIDTH, 4, width of the data word (≥2, any value).
- TICK_DIV, 4, clocks between automatic shifts in RUN state (≥1).
- RESET_VALUE, 0, value of data_out after reset (DATA_WIDTH bits).
- AMT_W, $clog2(DATA_WIDTH), width of shift_amount (derived localparam, not overridable).

Ports:
- FPGA_CLK  in  1  single system clock; all logic on its rising edge.
- RESET  in  1  synchronous, active-high reset.
- load  in  1  pulse; captures data_in into the data register.
- data_in  in  DATA_WIDTH  value to load.
- shift_amount  in  AMT_W  shift distance; sampled at each shift event.
- direction  in  1  0 = left, 1 = right.
- mode  in  2  00 logical, 01 arithmetic, 10 rotate, 11 reserved.
- run_en  in  1  level; 1 = automatic shifting.
- step  in  1  pulse; one shift while in IDLE.
- data_out  out  DATA_WIDTH  registered data word (drives the LEDs).
- tick  out  1  one-cycle pulse in the cycle data_out shows a shifted value.
- running  out  1  1 while in RUN state.

Behaviour:
- Reset: data_out=RESET_VALUE, tick=0, running=0, state=IDLE, divider counter=0. RESET has priority over every other input, including mid-RUN.
- States:
  - IDLE: data held; step=1 causes one shift event.
  - RUN: entered when run_en=1 in IDLE, with counter cleared. The counter counts 0..TICK_DIV-1, and a shift event occurs in the cycle the counter equals TICK_DIV-1; the counter then wraps to 0. With TICK_DIV=1, a shift occurs every cycle.
  - RUN→IDLE: when run_en=0; counter is cleared and no shift occurs in that cycle. step is ignored in RUN.
- running is registered and reflects the state: 1 the cycle after IDLE→RUN, 0 the cycle after RUN→IDLE.
- Priority per cycle: RESET > load > shift event.
  - load writes data_in and suppresses any coincident shift event and its tick.
  - load in RUN clears the counter, so the next shift comes TICK_DIV cycles later.
- Latency: data_out and tick update on the clock edge after the event cycle (1-cycle registered latency). tick is high for exactly one cycle per shift.
- Shift rules (combinational on the current data_out, amount a, width W):
  - logical: zero fill; a≥W → all zeros.
  - arithmetic right: sign fill from the MSB; a≥W → all copies of the MSB.
  - arithmetic left: identical to logical left.
  - rotate: by a mod W in the given direction.
  - a=0: data unchanged, but tick still pulses.
  - mode 11: data unchanged, tick still pulses.
- shift_amount, direction and mode may change on any cycle; only the values present in the event cycle matter.
- No combinational path from any input to any output.

Decomposition:
- Package shift_pkg holds:
  - mode localparams MODE_LOGIC, MODE_ARITH, MODE_ROT, MODE_RSVD;
  - direction localparams DIR_LEFT, DIR_RIGHT;
  - state encoding ST_IDLE, ST_RUN.
- One combinational sub-module, shift_core (DATA_WIDTH parameter; inputs data, amount, direction, mode; output shifted), implements the shift rules above.
- shift_runner contains the FSM, divider counter, data register and tick/running registers.

Test Plan:
- Reset: RESET=1 for 1 cycle with run_en=1 → data_out=0000, tick=0, running=0; RESET asserted mid-RUN → same values next cycle and counter restarts from 0 after release.
- Load/step, logical left: load 1011, then step with mode=00, dir=0, amt=1 → data_out=0110 one cycle after step; tick=1 for that single cycle.
- Auto rotate right: load 0001, mode=10, dir=1, amt=1, run_en=1, TICK_DIV=4 → ticks exactly 4 cycles apart; data_out sequence 1000, 0100, 0010, 0001, 1000; step pulses during RUN have no effect.
- Arithmetic and out-of-range amounts:
  - W=4: 1000 arith right amt 2 → 1110; 1001 arith left amt 1 → 0010.
  - DATA_WIDTH=6: 101101 logical right amt 7 → 000000; 101101 rotate right amt 7 → 110110.
- Load/tick collision: assert load=1, data_in=0101 in the cycle the counter hits TICK_DIV-1 → data_out=0101 with no tick; next tick occurs 4 cycles later.
- Run stop and reserved mode: drop run_en → running=0 next cycle, no further ticks; in IDLE, step with mode=11 → data_out unchanged, tick=1 for one cycle.
